// File: rtl/seven_segment_scanner.sv
// Multiplexed hex display driver: prescaled digit scan, PWM brightness and a
// frame-synchronous shadow/active register pair. Optional macro SEVEN_SEGMENT_LZB_EN enables leading-zero blanking.
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_BITS   = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   anode_signals,
  output logic [6:0]              display_out,
  output logic                    dp_out,
  output logic                    update_pending
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [DIV_BITS-1:0]     prescaler;
  logic [IDX_W-1:0]        digit_idx;
  logic                    slot_tick;
  logic                    commit_tick;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] active_digits;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic                    run;

  logic [3:0]              nibble;
  logic                    lit;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   anode_hi;
  logic [6:0]              seg_hi;
  logic                    dp_hi;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1111110;
      4'h1: decode = 7'b0110000;
      4'h2: decode = 7'b1101101;
      4'h3: decode = 7'b1111001;
      4'h4: decode = 7'b0110011;
      4'h5: decode = 7'b1011011;
      4'h6: decode = 7'b1011111;
      4'h7: decode = 7'b1110000;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1111011;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b0011111;
      4'hC: decode = 7'b1001110;
      4'hD: decode = 7'b0111101;
      4'hE: decode = 7'b1001111;
      default: decode = 7'b1000111;
    endcase
  endfunction

  assign slot_tick   = &prescaler;
  assign commit_tick = slot_tick && (digit_idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (!reset) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
      if (slot_tick)
        digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
    end
  end

  // A load landing on the commit tick bypasses the shadow so it shows next frame.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shadow_digits  <= '0;
      shadow_dp      <= '0;
      active_digits  <= '0;
      active_dp      <= '0;
      update_pending <= 1'b0;
    end else begin
      if (load) begin
        shadow_digits <= digits_in;
        shadow_dp     <= dp_in;
      end
      if (commit_tick) begin
        active_digits  <= load ? digits_in : shadow_digits;
        active_dp      <= load ? dp_in : shadow_dp;
        update_pending <= 1'b0;
      end else if (load) begin
        update_pending <= 1'b1;
      end
    end
  end

`ifdef SEVEN_SEGMENT_LZB_EN
  logic [4*NUM_DIGITS-1:0] upper;
  always_comb begin
    upper = active_digits >> (4 * digit_idx);
    blank = (digit_idx != '0) && (upper == '0);
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    nibble   = active_digits[4*digit_idx +: 4];
    lit      = prescaler[DIV_BITS-1 -: 4] < brightness;
    anode_hi = '0;
    seg_hi   = '0;
    dp_hi    = 1'b0;
    if (!blank) begin
      if (lit)
        anode_hi = NUM_DIGITS'(1) << digit_idx;
      seg_hi = decode(nibble);
      dp_hi  = active_dp[digit_idx];
    end
  end

  // run holds outputs dark for the first cycle after reset release.
  always_ff @(posedge clock) begin
    if (!reset) begin
      run           <= 1'b0;
      anode_signals <= {NUM_DIGITS{POL}};
      display_out   <= {7{POL}};
      dp_out        <= POL;
    end else begin
      run <= 1'b1;
      if (run) begin
        anode_signals <= anode_hi ^ {NUM_DIGITS{POL}};
        display_out   <= seg_hi ^ {7{POL}};
        dp_out        <= dp_hi ^ POL;
      end else begin
        anode_signals <= {NUM_DIGITS{POL}};
        display_out   <= {7{POL}};
        dp_out        <= POL;
      end
    end
  end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 Parameter DIV_BITS, default 16, prescaler width; one digit slot = 2^DIV_BITS clocks; SHALL be >= 4.
REQ-003 Parameter ACTIVE_LOW, default 1, 1 = anodes, segments and dp_out driven active-low; 0 = active-high.
REQ-004 clock  input  1  sole clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 load  input  1  single-cycle strobe, captures digits_in/dp_in.
REQ-007 digits_in  input  4*NUM_DIGITS  packed hex nibbles; nibble 0 = rightmost digit.
REQ-008 dp_in  input  NUM_DIGITS  decimal-point enables, bit i = digit i.
REQ-009 brightness  input  4  PWM duty in sixteenths; sampled every clock.
REQ-010 anode_signals  output  NUM_DIGITS  one-hot digit enable; bit i = digit i.
REQ-011 display_out  output  7  segments {a,b,c,d,e,f,g}, bit 6 = a.
REQ-012 dp_out  output  1  decimal-point segment.
REQ-013 update_pending  output  1  high while captured data awaits commit.

Function
REQ-014 Prescaler SHALL count 0..2^DIV_BITS-1 and wrap; slot_tick SHALL be asserted when prescaler is all ones.
REQ-015 Digit index SHALL advance on slot_tick, 0,1,..,NUM_DIGITS-1, wrapping to 0; wrap = frame boundary.
REQ-016 load SHALL write digits_in/dp_in into a shadow register and set update_pending on the next cycle.
REQ-017 Shadow SHALL be copied to the active register only on the slot_tick that wraps index to 0; update_pending clears same edge.
REQ-018 Repeated load before commit SHALL overwrite shadow; only the last value is committed.
REQ-019 load coincident with commit tick SHALL commit digits_in/dp_in directly; update_pending SHALL be 0 the following cycle.
REQ-020 Anode for current index SHALL be active only while prescaler[DIV_BITS-1:DIV_BITS-4] < brightness; brightness 0 = dark, 15 = 15/16 duty.
REQ-021 Nibble decode SHALL be 0-9 standard digits, 10-15 = A,b,C,d,E,F; active-high codes: 0=1111110, 1=0110000, 4=0110011, A=1110111, F=1000111.
REQ-022 All outputs SHALL be registered; outputs reflect index/prescaler with exactly 1 clock latency.
REQ-023 ACTIVE_LOW=1 SHALL invert anode_signals, display_out and dp_out relative to active-high codes.
REQ-024 At most one anode SHALL be active in any cycle; none active while brightness is 0.

Reset
REQ-025 While reset is low at a clock edge: prescaler, index, shadow, active register, update_pending SHALL go to 0.
REQ-026 During reset and on the first cycle after release, all anodes, segments and dp_out SHALL be inactive (all ones when ACTIVE_LOW=1).
REQ-027 Reset asserted mid-frame SHALL discard pending shadow data; no partial commit.

Configuration
REQ-028 Macro SEVEN_SEGMENT_LZB_EN: when defined, leading-zero blanking SHALL apply — zero digits above the most significant non-zero digit have anode held inactive; digit 0 never blanked; dp_in of a blanked digit ignored.
REQ-029 Without SEVEN_SEGMENT_LZB_EN every digit SHALL be displayed, including leading zeros.

Verification (NUM_DIGITS=4, DIV_BITS=4, ACTIVE_LOW=1)
REQ-030 Reset release, load 0x1234, brightness 15 -> after first frame boundary anodes cycle 1110,1101,1011,0111, each low 15 of 16 clocks; digit0 display_out=1001100.
REQ-031 load 0x0042: with LZB_EN digits 3,2 anodes stay 1; without LZB_EN they show display_out=0000001.
REQ-032 load 0x1111 then 0x2222 within one frame -> update_pending high from load+1 to commit; only 0x2222 ever displayed.
REQ-033 brightness 0 -> anode_signals=1111 every cycle; brightness 8 -> each anode low exactly 8 clocks per 16-clock slot.
REQ-034 load 0xABCD coincident with wrap tick -> 0xABCD active next frame, update_pending 0 next cycle; digit3 display_out=0001000.
REQ-035 Reset low mid-frame with pending load -> all outputs 1111/1111111/1 next edge; update_pending 0; old data not committed.
